seq_div_32b: RTL
================

Name: seq_div_32b

Overview:
- Multi-cycle 32-bit integer divider for the MIPS div/divu path; produces the HI (remainder) and LO (quotient) values.
- Restoring shift-and-subtract algorithm, one quotient bit per cycle.
- Sits beside the ALU and adder. The datapath stalls on busy and latches the results on done.

Parameters:
- WIDTH, 32, operand/result width; the design and test plan assume 32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = div (two's complement), 0 = divu; captured with start
- dividend  input  WIDTH  numerator; captured with start
- divisor  input  WIDTH  denominator; captured with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  LO result
- remainder  output  WIDTH  HI result
- div_by_zero  output  1  set with done when divisor == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, div_by_zero, quotient, remainder, iteration counter all 0. Reset mid-operation aborts immediately. No partial result is ever signalled.
- States: IDLE, RUN, FIX, DONE.
- IDLE: on edge N with start=1, capture the operands.
  - Signed mode: store absolute values as unsigned 32-bit (|0x80000000| = 0x80000000). Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Unsigned mode: q_neg = r_neg = 0.
  - divisor == 0: go to DONE, skipping RUN.
  - Otherwise: go to RUN with counter=0, busy=1.
- RUN, each cycle:
  - Form the 33-bit partial remainder {rem[31:0], dvd[31]} and shift the dividend left.
  - If the trial subtract of the divisor is non-negative, keep the difference and shift in quotient bit 1; else keep the shifted value and shift in 0.
  - 32 iterations (counter 0..31). At counter==31, go to FIX.
- FIX: quotient = q_neg ? -q : q. remainder = r_neg ? -r : r (two's complement, 32-bit wrap). Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency, normal path:
  - busy is high after edges N+1..N+33.
  - quotient/remainder are updated at edge N+33.
  - done is high in the cycle after edge N+34.
- Latency, divide-by-zero:
  - done and div_by_zero are high in the cycle after edge N+1.
  - quotient = 0xFFFFFFFF and remainder = dividend as captured (raw, no sign fix), in both modes.
  - busy never asserts.
- div_by_zero clears when the next start is accepted.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the algorithm; no special case.
- Sign rules: truncation toward zero. Remainder takes the dividend's sign; remainder 0 is never negated to a nonzero value.
- start while not in IDLE (RUN/FIX/DONE) is ignored; the operands are not re-captured.
- Back-to-back: start in the cycle after done is accepted, since the state is IDLE.
- quotient/remainder hold their last values until the next FIX or divide-by-zero completion.

Optional Feature:
- Macro: SEQ_DIV_RADIX4_EN.
- Defined:
  - Two quotient bits per RUN cycle; counter 0..15; 16 iterations.
  - Normal-path done in the cycle after edge N+18; busy high after edges N+1..N+17.
  - Results bit-identical to the radix-2 build; divide-by-zero timing unchanged.
- Undefined: radix-2, 32 iterations, as above.

Test Plan:
- Unsigned 100 / 7, start at edge N -> busy after N+1..N+33; done pulse after N+34; quotient=14, remainder=2, div_by_zero=0.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7 / 0xFFFFFFFE (-2) -> quotient=0xFFFFFFFD, remainder=1.
- 0x12345678 / 0 (either mode) -> done and div_by_zero after N+1; quotient=0xFFFFFFFF, remainder=0x12345678, busy stays 0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Start 0xFFFFFFFF / 0x10 unsigned, then pulse start with 5 / 1 during RUN -> second request ignored; quotient=0x0FFFFFFF, remainder=0xF. A new start in the cycle after done is accepted.
- Drop rst_n at RUN iteration 10 -> busy, done, quotient, remainder, div_by_zero all 0 immediately. Release, then 9 / 3 -> quotient=3, remainder=0 with normal latency.

Source files
------------

// File: rtl/seq_div_32b.sv
// seq_div_32b: multi-cycle restoring divider for the MIPS div/divu path (LO = quotient, HI = remainder).
// Optional macro SEQ_DIV_RADIX4_EN: retire two quotient bits per RUN cycle (16 iterations instead of 32).
module seq_div_32b #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

`ifdef SEQ_DIV_RADIX4_EN
   localparam int ITERS = WIDTH / 2;
`else
   localparam int ITERS = WIDTH;
`endif
   localparam int               CNT_W    = $clog2(ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   remo_q, remo_d;
   logic               dvd_neg, dvs_neg;

   // One restoring step: returns {next remainder, dividend shifted left with the new quotient bit}.
   // dvd doubles as the quotient register: quotient bits enter at the LSB as dividend bits leave.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] dvd,
                                                    input logic [WIDTH-1:0] dvs);
      logic [WIDTH:0]   part;
      logic             ge;
      logic [WIDTH-1:0] rem_nxt;
      part    = {rem, dvd[WIDTH-1]};
      ge      = (part >= {1'b0, dvs});
      rem_nxt = ge ? (part[WIDTH-1:0] - dvs) : part[WIDTH-1:0];
      return {rem_nxt, dvd[WIDTH-2:0], ge};
   endfunction

   function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign dvd_neg = is_signed & dividend[WIDTH-1];
   assign dvs_neg = is_signed & divisor[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quo_q   <= '0;
         remo_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         quo_q   <= quo_d;
         remo_q  <= remo_d;
      end
   end

   // busy/done are registered decodes of the state, so they trail the state by one edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dz_d    = dz_q;
      dbz_d   = dbz_q;
      quo_d   = quo_q;
      remo_d  = remo_q;
      busy_d  = (state_q == RUN) || (state_q == FIX);
      done_d  = (state_q == DONE);
      case (state_q)
         IDLE: begin
            if (start) begin
               q_neg_d = dvd_neg ^ dvs_neg;
               r_neg_d = dvd_neg;
               dz_d    = (divisor == '0);
               dbz_d   = 1'b0;
               cnt_d   = '0;
               rem_d   = '0;
               dvs_d   = neg_if(dvs_neg, divisor);
               if (divisor == '0) begin
                  dvd_d   = dividend;
                  state_d = DONE;
               end else begin
                  dvd_d   = neg_if(dvd_neg, dividend);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            {rem_d, dvd_d} = div_step(rem_q, dvd_q, dvs_q);
`ifdef SEQ_DIV_RADIX4_EN
            {rem_d, dvd_d} = div_step(rem_d, dvd_d, dvs_q);
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = FIX;
            end
         end
         FIX: begin
            quo_d   = neg_if(q_neg_q, dvd_q);
            remo_d  = neg_if(r_neg_q, rem_q);
            state_d = DONE;
         end
         DONE: begin
            if (dz_q) begin
               quo_d  = '1;
               remo_d = dvd_q;
               dbz_d  = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;

endmodule
